// File: rtl/mem_pkg.sv
// Shared definitions for the memory size controller: access-size encodings,
// controller FSM states and lane widths.
package mem_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } memSize_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    RESP
  } memState_e;

  // The reserved size code behaves as a full word access.
  function automatic memSize_e normSize(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : memSize_e'(sz);
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Lane extract and sign/zero extension of a memory word for loads.
// Ports:
//   word       - full memory word
//   laneSel    - byte lane of the access (already aligned to the size)
//   size       - access size (byte / half / word)
//   isUnsigned - 1 = zero-extend, 0 = sign-extend
//   extData_c  - right-justified, extended result (combinational)
module mem_lane_ext
  import mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] laneSel,
  input  memSize_e          size,
  input  logic              isUnsigned,
  output logic [DATA_W-1:0] extData_c
);

  logic [DATA_W-1:0] shifted;
  logic              fillBit;

  // Right-justify the addressed lane, then extend from the field's top bit.
  always_comb begin
    shifted   = word >> {laneSel, 3'b000};
    fillBit   = 1'b0;
    extData_c = shifted;
    case (size)
      SZ_BYTE: begin
        fillBit   = ~isUnsigned & shifted[BYTE_W-1];
        extData_c = {{(DATA_W - BYTE_W){fillBit}}, shifted[BYTE_W-1:0]};
      end
      SZ_HALF: begin
        fillBit   = ~isUnsigned & shifted[HALF_W-1];
        extData_c = {{(DATA_W - HALF_W){fillBit}}, shifted[HALF_W-1:0]};
      end
      default: extData_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_size_ctrl.sv
// Memory size controller: turns byte/half/word load and store requests into
// full-word memory reads and writes (read-modify-write for sub-word stores).
// Optional feature: define MEM_SIZE_MISALIGN_TRAP_EN to report misaligned
// accesses through rsp_err without touching memory; otherwise misaligned
// addresses are truncated to the natural alignment of the access size.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   req_valid/req_ready             - request handshake (ready only when idle)
//   req_we/req_size/req_unsigned    - store flag, size code, zero-extend flag
//   req_addr/req_wdata              - byte address, store data
//   mem_addr/mem_wr/mem_wdata       - word-aligned memory port (write side)
//   mem_rdata                       - read data, one cycle after mem_addr
//   rsp_valid/rsp_rdata/rsp_err     - completion pulse, load result, error
module mem_size_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned LANE_W = $clog2(DATA_W / 8);

  memState_e         state, stateNext;
  logic              capWe, capWeNext;
  logic              capUns, capUnsNext;
  memSize_e          capSize, capSizeNext, reqSize;
  logic [LANE_W-1:0] capLane, capLaneNext, reqLane;
  logic [HALF_W-1:0] capWdata, capWdataNext;
  logic [ADDR_W-1:0] wordAddr, memAddrNext;
  logic [DATA_W-1:0] memWdataNext, rspRdataNext;
  logic [DATA_W-1:0] laneMask, laneData, mergeWord, loadExt;
  logic [LANE_W+2:0] shamt;
  logic              reqReadyNext, memWrNext, rspValidNext, rspErrNext;
`ifdef MEM_SIZE_MISALIGN_TRAP_EN
  logic              misaligned;
`endif

  mem_lane_ext #(.DATA_W(DATA_W)) u_laneExt (
    .word      (mem_rdata),
    .laneSel   (capLane),
    .size      (capSize),
    .isUnsigned(capUns),
    .extData_c (loadExt)
  );

  // Next-state, capture and output decode.
  always_comb begin
    stateNext    = state;
    capWeNext    = capWe;
    capUnsNext   = capUns;
    capSizeNext  = capSize;
    capLaneNext  = capLane;
    capWdataNext = capWdata;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    rspRdataNext = rsp_rdata;
    rspErrNext   = 1'b0;

    // Request decode: size normalisation and lane truncation to alignment.
    reqSize  = normSize(req_size);
    reqLane  = req_addr[LANE_W-1:0];
    case (reqSize)
      SZ_HALF: reqLane[0] = 1'b0;
      SZ_WORD: reqLane    = '0;
      default: ;
    endcase
    wordAddr = {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
`ifdef MEM_SIZE_MISALIGN_TRAP_EN
    misaligned = ((reqSize == SZ_HALF) && req_addr[0]) ||
                 ((reqSize == SZ_WORD) && (req_addr[LANE_W-1:0] != '0));
`endif

    // Sub-word store merge: replace only the addressed lane(s) of the read word.
    shamt = {capLane, 3'b000};
    if (capSize == SZ_BYTE) begin
      laneMask = DATA_W'({BYTE_W{1'b1}}) << shamt;
      laneData = DATA_W'(capWdata[BYTE_W-1:0]) << shamt;
    end else begin
      laneMask = DATA_W'({HALF_W{1'b1}}) << shamt;
      laneData = DATA_W'(capWdata) << shamt;
    end
    mergeWord = (mem_rdata & ~laneMask) | laneData;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          capWeNext    = req_we;
          capUnsNext   = req_unsigned;
          capSizeNext  = reqSize;
          capLaneNext  = reqLane;
          capWdataNext = req_wdata[HALF_W-1:0];
          rspRdataNext = '0;
          memAddrNext  = wordAddr;
          if (req_we && (reqSize == SZ_WORD)) begin
            stateNext    = WR;
            memWdataNext = req_wdata;
          end else begin
            stateNext = RD;
          end
`ifdef MEM_SIZE_MISALIGN_TRAP_EN
          // Trapped accesses skip memory entirely.
          if (misaligned) begin
            stateNext    = RESP;
            rspErrNext   = 1'b1;
            memAddrNext  = mem_addr;
            memWdataNext = mem_wdata;
          end
`endif
        end
      end
      RD:   stateNext = RDW;
      RDW: begin
        if (capWe) begin
          stateNext    = WR;
          memWdataNext = mergeWord;
        end else begin
          stateNext    = RESP;
          rspRdataNext = loadExt;
        end
      end
      WR:      stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Outputs are registered against the state being entered.
    reqReadyNext = (stateNext == IDLE);
    memWrNext    = (stateNext == WR);
    rspValidNext = (stateNext == RESP);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      capWe     <= 1'b0;
      capUns    <= 1'b0;
      capSize   <= SZ_WORD;
      capLane   <= '0;
      capWdata  <= '0;
      req_ready <= 1'b1;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= stateNext;
      capWe     <= capWeNext;
      capUns    <= capUnsNext;
      capSize   <= capSizeNext;
      capLane   <= capLaneNext;
      capWdata  <= capWdataNext;
      req_ready <= reqReadyNext;
      mem_addr  <= memAddrNext;
      mem_wr    <= memWrNext;
      mem_wdata <= memWdataNext;
      rsp_valid <= rspValidNext;
      rsp_rdata <= rspRdataNext;
      rsp_err   <= rspErrNext;
    end
  end

endmodule

// File: tb/tb_mem_size_ctrl.sv
// Self-checking bench for mem_size_ctrl: a 32-bit instance driven by directed
// and random requests against a byte-array reference model, and a 64-bit
// instance exercising lane handling in a wider word.
module tb_mem_size_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rsp_rdata;
  logic        mem_wr, rsp_valid, rsp_err;

  logic        req_valid64, req_ready64, req_we64, req_unsigned64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64, mem_addr64;
  logic [63:0] req_wdata64, mem_wdata64, mem_rdata64, rsp_rdata64;
  logic        mem_wr64, rsp_valid64, rsp_err64;

  int nTests = 0;
  int nFail  = 0;

  mem_size_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_size_ctrl #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
    .req_size(req_size64), .req_unsigned(req_unsigned64), .req_addr(req_addr64),
    .req_wdata(req_wdata64), .mem_addr(mem_addr64), .mem_wr(mem_wr64),
    .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64), .rsp_valid(rsp_valid64),
    .rsp_rdata(rsp_rdata64), .rsp_err(rsp_err64)
  );

  // Synchronous memories with a bench-side preload port.
  logic [31:0] memArr [16];
  logic [63:0] mem64 [8];
  logic        tbWrEn = 1'b0, tb64WrEn = 1'b0;
  logic [3:0]  tbWrIdx = '0;
  logic [31:0] tbWrData = '0;
  logic [63:0] tb64WrData = '0;
  int          writeCount = 0, rspCount = 0, writeCount64 = 0;
  logic [31:0] lastWrAddr = '0, lastWrData = '0, lastWrAddr64 = '0;
  logic [63:0] lastWrData64 = '0;

  always @(posedge clk) begin
    mem_rdata <= memArr[mem_addr[5:2]];
    if (tbWrEn) memArr[tbWrIdx] <= tbWrData;
    else if (mem_wr === 1'b1) begin
      memArr[mem_addr[5:2]] <= mem_wdata;
      writeCount <= writeCount + 1;
      lastWrAddr <= mem_addr;
      lastWrData <= mem_wdata;
    end
    if (rsp_valid === 1'b1) rspCount <= rspCount + 1;
  end

  always @(posedge clk) begin
    mem_rdata64 <= mem64[mem_addr64[5:3]];
    if (tb64WrEn) mem64[0] <= tb64WrData;
    else if (mem_wr64 === 1'b1) begin
      mem64[mem_addr64[5:3]] <= mem_wdata64;
      writeCount64 <= writeCount64 + 1;
      lastWrAddr64 <= mem_addr64;
      lastWrData64 <= mem_wdata64;
    end
  end

  // Reference memory, byte granular.
  logic [7:0] refBytes [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input int idx);
    return {refBytes[4*idx+3], refBytes[4*idx+2], refBytes[4*idx+1], refBytes[4*idx]};
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic setWord(input int idx, input logic [31:0] val);
    for (int i = 0; i < 4; i++) refBytes[4*idx+i] = val[8*i +: 8];
    tbWrEn = 1'b1; tbWrIdx = 4'(idx); tbWrData = val;
    @(posedge clk);
    @(negedge clk);
    tbWrEn = 1'b0;
  endtask

  // Access rules applied to the byte array: latency, result, error, writes.
  task automatic refAccess(input logic we, input logic [1:0] size, input logic uns,
                           input logic [5:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata,
                           output logic err, output int writes);
    int nb, ea;
    logic [31:0] val;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = 1'b0; rdata = '0; writes = 0; lat = 0;
`ifdef MEM_SIZE_MISALIGN_TRAP_EN
    if ((int'(addr) % nb) != 0) begin
      lat = 1; err = 1'b1;
      return;
    end
`endif
    ea = int'(addr) - (int'(addr) % nb);
    if (we) begin
      for (int i = 0; i < nb; i++) refBytes[ea+i] = wdata[8*i +: 8];
      lat = (nb == 4) ? 2 : 4;
      writes = 1;
    end else begin
      val = '0;
      for (int i = 0; i < nb; i++) val = val | (32'(refBytes[ea+i]) << (8*i));
      if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      rdata = val;
      lat = 3;
    end
  endtask

  // One request on the 32-bit instance, checked against the reference model.
  task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata,
                       input string tag, output logic [31:0] gotRd, output logic gotErr);
    int expLat, expWr, lat, w0;
    logic [31:0] expRd;
    logic expErr;
    refAccess(we, size, uns, addr, wdata, expLat, expRd, expErr, expWr);
    check({tag, "/ready"}, 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = 32'(addr); req_wdata = wdata;
    w0 = writeCount;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    gotRd = rsp_rdata; gotErr = rsp_err;
    check({tag, "/latency"}, 64'(lat), 64'(expLat));
    check({tag, "/rdata"}, 64'(rsp_rdata), 64'(expRd));
    check({tag, "/err"}, 64'(rsp_err), 64'(expErr));
    check({tag, "/writes"}, 64'(writeCount - w0), 64'(expWr));
    check({tag, "/memword"}, 64'(memArr[addr[5:2]]), 64'(refWord(int'(addr[5:2]))));
    if (!expErr) check({tag, "/memaddr"}, 64'(mem_addr), 64'({26'd0, addr[5:2], 2'b00}));
    @(negedge clk);
    check({tag, "/rsp_one_cycle"}, 64'(rsp_valid), 64'(1'b0));
  endtask

  // One request on the 64-bit instance.
  task automatic doReq64(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         output int lat, output logic [63:0] rd, output int writes);
    int w0;
    w0 = writeCount64;
    req_valid64 = 1'b1; req_we64 = we; req_size64 = size; req_unsigned64 = uns;
    req_addr64 = addr; req_wdata64 = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid64 = 1'b0;
    lat = 1;
    while (rsp_valid64 !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata64;
    writes = writeCount64 - w0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [63:0] rd64;
    int          lat64, wr64, w0, r0;

    reset = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    req_valid64 = 1'b1; req_we64 = 1'b0; req_size64 = 2'b10; req_unsigned64 = 1'b0;
    req_addr64 = 32'h8; req_wdata64 = '0;

    // Preload while reset is held with req_valid asserted.
    @(negedge clk);
    for (int i = 0; i < 16; i++) setWord(i, $urandom);
    tb64WrEn = 1'b1; tb64WrData = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    @(negedge clk);
    tb64WrEn = 1'b0;

    check("reset/ready", 64'(req_ready), 64'(1'b1));
    check("reset/mem_wr", 64'(mem_wr), 64'(1'b0));
    check("reset/rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("reset/rsp_err", 64'(rsp_err), 64'(1'b0));
    check("reset/rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset/mem_addr", 64'(mem_addr), 64'd0);
    check("reset/mem_wdata", 64'(mem_wdata), 64'd0);
    check("reset/ready64", 64'(req_ready64), 64'(1'b1));
    reset = 1'b0; req_valid = 1'b0; req_valid64 = 1'b0;
    @(negedge clk);

    // Word load.
    setWord(4, 32'h8899_AABB);
    doReq(1'b0, 2'b10, 1'b0, 6'h10, '0, "lw", rd, er);
    check("lw/value", 64'(rd), 64'h8899_AABB);

    // Byte loads, signed and unsigned, from the top lane.
    setWord(4, 32'h8011_2233);
    doReq(1'b0, 2'b00, 1'b0, 6'h13, '0, "lb", rd, er);
    check("lb/value", 64'(rd), 64'hFFFF_FF80);
    doReq(1'b0, 2'b00, 1'b1, 6'h13, '0, "lbu", rd, er);
    check("lbu/value", 64'(rd), 64'h0000_0080);

    // Byte store read-modify-write.
    setWord(8, 32'h1122_3344);
    doReq(1'b1, 2'b00, 1'b0, 6'h21, 32'h0000_00EE, "sb", rd, er);
    check("sb/wr_addr", 64'(lastWrAddr), 64'h20);
    check("sb/wr_data", 64'(lastWrData), 64'h1122_EE44);

    // Misaligned halfword load.
    setWord(0, 32'hA1B2_C3D4);
    doReq(1'b0, 2'b01, 1'b0, 6'h03, '0, "lh_mis", rd, er);
`ifdef MEM_SIZE_MISALIGN_TRAP_EN
    check("lh_mis/err", 64'(er), 64'(1'b1));
    check("lh_mis/value", 64'(rd), 64'd0);
`else
    check("lh_mis/err", 64'(er), 64'(1'b0));
    check("lh_mis/value", 64'(rd), 64'hFFFF_A1B2);
`endif

    // Reserved size code behaves as a word.
    setWord(6, 32'h5566_7788);
    doReq(1'b0, 2'b11, 1'b0, 6'h18, '0, "lrsvd", rd, er);
    check("lrsvd/value", 64'(rd), 64'h5566_7788);

    // Reset in RDW of a halfword store aborts it.
    setWord(8, 32'hCAFE_F00D);
    w0 = writeCount; r0 = rspCount;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort/ready", 64'(req_ready), 64'(1'b1));
    check("abort/mem_wr", 64'(mem_wr), 64'(1'b0));
    check("abort/rsp_valid", 64'(rsp_valid), 64'(1'b0));
    check("abort/mem_addr", 64'(mem_addr), 64'd0);
    repeat (5) @(negedge clk);
    check("abort/writes", 64'(writeCount - w0), 64'd0);
    check("abort/rsps", 64'(rspCount - r0), 64'd0);
    check("abort/memword", 64'(memArr[8]), 64'hCAFE_F00D);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      doReq(1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom_range(0, 63)),
            $urandom, $sformatf("rnd%0d", n), rd, er);
    end

    // 64-bit word: halfword store into the top lane, then loads.
    doReq64(1'b1, 2'b01, 1'b0, 32'h06, 64'h0000_BEEF, lat64, rd64, wr64);
    check("sh64/latency", 64'(lat64), 64'd4);
    check("sh64/writes", 64'(wr64), 64'd1);
    check("sh64/wr_addr", 64'(lastWrAddr64), 64'd0);
    check("sh64/wr_data", lastWrData64, 64'hBEEF_4567_89AB_CDEF);
    doReq64(1'b0, 2'b01, 1'b0, 32'h06, '0, lat64, rd64, wr64);
    check("lh64/latency", 64'(lat64), 64'd3);
    check("lh64/value", rd64, 64'hFFFF_FFFF_FFFF_BEEF);
    doReq64(1'b0, 2'b00, 1'b1, 32'h05, '0, lat64, rd64, wr64);
    check("lbu64/value", rd64, 64'h45);
    doReq64(1'b0, 2'b10, 1'b0, 32'h00, '0, lat64, rd64, wr64);
    check("ld64/value", rd64, 64'hBEEF_4567_89AB_CDEF);
    check("ld64/writes", 64'(wr64), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
